// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: pc/phase_fetch/flush in, instruction memory port, decode-side results out.
// master = fetch unit, slave = surrounding core and memory.
interface instruction_fetch_if;
    logic        phase_fetch;
    logic [31:0] pc;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        input  phase_fetch, pc, flush, mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_busy, fault, fault_cause
    );

    modport slave (
        output phase_fetch, pc, flush, mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_busy, fault, fault_cause
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding word read per fetch phase, with misalignment,
// bus-error and timeout faults, and flush/drain handling for redirected control flow.
module instruction_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input logic                 clk,
    input logic                 rstn,
    instruction_fetch_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        drain_done_q, drain_done_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic accept_s;
    logic misalign_s;
    logic timeout_s;
    logic data_done_s;

    assign accept_s    = (state_q == S_IDLE) && bus.phase_fetch && !bus.flush;
    assign misalign_s  = (bus.pc[1:0] != 2'b00);
    assign timeout_s   = (cnt_q == TO_LAST);
    assign data_done_s = ((state_q == S_REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                         ((state_q == S_WAIT) && bus.mem_rvalid);

    // State register and fetch datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            drain_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= 32'd0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            cause_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_done_q <= drain_done_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
        end
    end

    // Next-state logic; drain_done marks a drain that must still report a timeout
    always_comb begin
        state_d      = state_q;
        drain_done_d = drain_done_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d      = misalign_s ? S_DONE : S_REQ;
                    drain_done_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.flush) begin
                    // A grant without data leaves a response in flight that must be absorbed
                    if (bus.mem_gnt && !bus.mem_rvalid) begin
                        state_d      = S_DRAIN;
                        drain_done_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.mem_gnt && bus.mem_rvalid) begin
                    state_d = S_DONE;
                end else if (bus.mem_gnt) begin
                    if (timeout_s) begin
                        state_d      = S_DRAIN;
                        drain_done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.flush) begin
                    if (bus.mem_rvalid) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_DRAIN;
                        drain_done_d = 1'b0;
                    end
                end else if (bus.mem_rvalid) begin
                    state_d = S_DONE;
                end else if (timeout_s) begin
                    state_d      = S_DRAIN;
                    drain_done_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) begin
                    state_d = drain_done_q ? S_DONE : S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values: result fields move only on accept or on entry to DONE
    always_comb begin
        mem_req_d  = (state_d == S_REQ);
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        valid_d    = (state_d == S_DONE);
        if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (accept_s) begin
            cnt_d      = 8'd0;
            mem_addr_d = bus.pc;
            instr_pc_d = bus.pc;
            if (misalign_s) begin
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
                cause_d = 2'b01;
            end else begin
                fault_d = 1'b0;
                cause_d = 2'b00;
            end
        end else if (state_d == S_DONE) begin
            if (data_done_s && !bus.mem_err) begin
                instr_d = bus.mem_rdata;
                fault_d = 1'b0;
                cause_d = 2'b00;
            end else if (data_done_s) begin
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
                cause_d = 2'b10;
            end else begin
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
                cause_d = 2'b11;
            end
        end else begin
            instr_d = instr_q;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    // A flush landing in DONE cancels the pulse while the result fields still update
    assign bus.instr_valid = valid_q && !bus.flush;
    assign bus.fetch_busy  = (state_q != S_IDLE);
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected decode results, a monitor pops them.
module tb_instruction_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fails;
    exp_t exp_q[$];

    instruction_fetch_if bif ();

    instruction_fetch #(.TIMEOUT_CYCLES(8), .NOP_INSTR(NOP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [31:0] i, input logic [31:0] p, input logic f, input logic [1:0] c);
        exp_t e;
        e.instr = i; e.pc = p; e.fault = f; e.cause = c;
        exp_q.push_back(e);
    endtask

    task automatic start(input logic [31:0] p);
        bif.phase_fetch = 1'b1;
        bif.pc          = p;
        step();
        bif.phase_fetch = 1'b0;
    endtask

    // Monitor: every decode pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rstn && bif.instr_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_valid: got instr %h pc %h expected no pulse", bif.instr, bif.instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_instr", bif.instr, e.instr);
                chk("sb_pc", bif.instr_pc, e.pc);
                chk("sb_fault", {31'd0, bif.fault}, {31'd0, e.fault});
                chk("sb_cause", {30'd0, bif.fault_cause}, {30'd0, e.cause});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rstn = 1'b0;
        bif.phase_fetch = 1'b0; bif.pc = 32'd0; bif.flush = 1'b0;
        bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b0; bif.mem_rdata = 32'd0; bif.mem_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bif.mem_req}, 32'd0);
        chk("rst_addr", bif.mem_addr, 32'd0);
        chk("rst_instr", bif.instr, NOP);
        chk("rst_ipc", bif.instr_pc, 32'd0);
        chk("rst_fault", {29'd0, bif.fault, bif.fault_cause}, 32'd0);
        chk("rst_busy", {31'd0, bif.fetch_busy}, 32'd0);
        rstn = 1'b1;
        step();

        // Zero-wait fetch: IDLE -> REQ -> DONE
        start(32'h0000_0100);
        chk("zw_req", {31'd0, bif.mem_req}, 32'd1);
        chk("zw_addr", bif.mem_addr, 32'h0000_0100);
        bif.mem_gnt = 1'b1; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'h0050_0093;
        expect_result(32'h0050_0093, 32'h0000_0100, 1'b0, 2'b00);
        step();
        bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b0;
        chk("zw_valid", {31'd0, bif.instr_valid}, 32'd1);
        chk("zw_req_drop", {31'd0, bif.mem_req}, 32'd0);
        step();
        chk("zw_pulse_end", {31'd0, bif.instr_valid}, 32'd0);

        // Wait states: grant after 2 cycles, data 3 cycles later
        start(32'h0000_0104);
        step();
        step();
        chk("ws_req_held", {31'd0, bif.mem_req}, 32'd1);
        bif.mem_gnt = 1'b1;
        step();
        bif.mem_gnt = 1'b0;
        chk("ws_req_after_gnt", {31'd0, bif.mem_req}, 32'd0);
        step();
        step();
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hFFDF_F06F;
        expect_result(32'hFFDF_F06F, 32'h0000_0104, 1'b0, 2'b00);
        step();
        bif.mem_rvalid = 1'b0;
        chk("ws_valid", {31'd0, bif.instr_valid}, 32'd1);
        step();

        // Misaligned pc: straight to DONE with no request
        expect_result(NOP, 32'h0000_0102, 1'b1, 2'b01);
        start(32'h0000_0102);
        chk("mis_no_req", {31'd0, bif.mem_req}, 32'd0);
        chk("mis_valid", {31'd0, bif.instr_valid}, 32'd1);
        step();
        chk("mis_no_req2", {31'd0, bif.mem_req}, 32'd0);

        // Bus error on a zero-wait response
        start(32'h0000_0108);
        bif.mem_gnt = 1'b1; bif.mem_rvalid = 1'b1; bif.mem_err = 1'b1; bif.mem_rdata = 32'h1234_5678;
        expect_result(NOP, 32'h0000_0108, 1'b1, 2'b10);
        step();
        bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b0; bif.mem_err = 1'b0;
        step();

        // Timeout in REQ: request held exactly 8 cycles
        expect_result(NOP, 32'h0000_010C, 1'b1, 2'b11);
        start(32'h0000_010C);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_req_%0d", i), {31'd0, bif.mem_req}, 32'd1);
            step();
        end
        chk("to_req_drop", {31'd0, bif.mem_req}, 32'd0);
        chk("to_valid", {31'd0, bif.instr_valid}, 32'd1);
        step();

        // Timeout in WAIT: drains the late response, then reports the timeout
        start(32'h0000_0110);
        bif.mem_gnt = 1'b1;
        step();
        bif.mem_gnt = 1'b0;
        repeat (7) step();
        chk("tow_drain_busy", {31'd0, bif.fetch_busy}, 32'd1);
        chk("tow_no_valid", {31'd0, bif.instr_valid}, 32'd0);
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hAAAA_5555;
        expect_result(NOP, 32'h0000_0110, 1'b1, 2'b11);
        step();
        bif.mem_rvalid = 1'b0;
        chk("tow_valid", {31'd0, bif.instr_valid}, 32'd1);
        step();

        // Flush in WAIT: response discarded, instr keeps the previous word
        start(32'h0000_0114);
        bif.mem_gnt = 1'b1;
        step();
        bif.mem_gnt = 1'b0;
        bif.flush = 1'b1;
        step();
        bif.flush = 1'b0;
        step();
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hDEAD_BEEF;
        step();
        bif.mem_rvalid = 1'b0;
        chk("fl_no_valid", {31'd0, bif.instr_valid}, 32'd0);
        chk("fl_instr_hold", bif.instr, NOP);
        chk("fl_fault_clr", {31'd0, bif.fault}, 32'd0);
        chk("fl_idle", {31'd0, bif.fetch_busy}, 32'd0);
        start(32'h0000_0200);
        bif.mem_gnt = 1'b1; bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'h0000_0297;
        expect_result(32'h0000_0297, 32'h0000_0200, 1'b0, 2'b00);
        step();
        bif.mem_gnt = 1'b0; bif.mem_rvalid = 1'b0;
        step();

        // Flush in IDLE blocks phase_fetch
        bif.flush = 1'b1;
        start(32'h0000_0300);
        bif.flush = 1'b0;
        chk("fli_no_req", {31'd0, bif.mem_req}, 32'd0);
        chk("fli_idle", {31'd0, bif.fetch_busy}, 32'd0);

        // Reset during WAIT: outputs return to reset values immediately
        start(32'h0000_0400);
        bif.mem_gnt = 1'b1;
        step();
        bif.mem_gnt = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        chk("mr_req", {31'd0, bif.mem_req}, 32'd0);
        chk("mr_addr", bif.mem_addr, 32'd0);
        chk("mr_instr", bif.instr, NOP);
        chk("mr_ipc", bif.instr_pc, 32'd0);
        chk("mr_busy", {31'd0, bif.fetch_busy}, 32'd0);
        step();
        rstn = 1'b1;
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hCAFE_F00D;
        step();
        bif.mem_rvalid = 1'b0;
        chk("mr_late_no_valid", {31'd0, bif.instr_valid}, 32'd0);
        chk("mr_late_instr", bif.instr, NOP);
        step();
        step();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
